// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
// The optional BRU_STATS_EN build adds branch/mispredict statistics counters to the top.
package bru_pkg;

    localparam int          PC_W    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    // Resolve FSM: normal operation, or squashing the pipeline after a redirect
    typedef enum logic [0:0] {
        BRU_IDLE  = 1'b0,
        BRU_FLUSH = 1'b1
    } bru_state_e;

    // Prediction metadata captured at fetch, consumed when the instruction leaves the ALU
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            prediction;
        logic            taken;
        logic [PC_W-1:0] pred_pc;
    } bru_entry_t;

    // Sequential fall-through address, wrapping at 32 bits
    function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/bru_pred_queue.sv
// In-order FIFO of in-flight prediction entries.
// Pop of an empty queue and push into a full queue without a pop are ignored;
// clear empties the queue in one cycle and takes priority over push/pop.
module bru_pred_queue
    import bru_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rsn_i,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  bru_entry_t wr_entry,
    output bru_entry_t rd_entry,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    bru_entry_t       mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (count == CNT_W'(QUEUE_DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign rd_entry = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is a power of two)
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage carries data only, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares each retiring instruction's fetch-time prediction with
// its resolved outcome, feeds the predictor, and redirects/flushes on a mispredict.
// Optional build macro BRU_STATS_EN adds stat_branch_o / stat_mispredict_o counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int QUEUE_DEPTH  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_prediction_i,
    input  logic        fetch_taken_i,
    input  logic [31:0] fetch_pred_pc_i,
    input  logic        ex_valid_i,
    input  logic        ex_branch_i,
    input  logic        ex_jumps_i,
    input  logic [31:0] ex_target_pc_i,
    output logic        fetch_stall_o,
    output logic        bp_branch_o,
    output logic        bp_jumps_o,
    output logic        bp_prediction_o,
    output logic        bp_taken_o,
    output logic        bp_pc_ok_o,
    output logic [31:0] bp_branch_pc_o,
    output logic [31:0] bp_target_pc_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
`ifdef BRU_STATS_EN
    output logic [31:0] stat_branch_o,
    output logic [31:0] stat_mispredict_o,
`endif
    output logic        flush_o
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    bru_state_e       state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;

    bru_entry_t       wr_entry;
    bru_entry_t       rd_entry;
    bru_entry_t       head;
    logic             q_full;
    logic             q_empty;
    logic             pop_req;
    logic             push_req;
    logic             mispredict;
    logic [31:0]      predicted_next;
    logic [31:0]      actual_next;

    // Registered predictor feedback and redirect
    logic             fb_branch_p1;
    logic             fb_jumps_p1;
    logic             fb_prediction_p1;
    logic             fb_taken_p1;
    logic             fb_pc_ok_p1;
    logic [31:0]      fb_branch_pc_p1;
    logic [31:0]      fb_target_pc_p1;
    logic             redirect_vld_p1;
    logic [31:0]      redirect_pc_p1;

    assign wr_entry = '{pc:         fetch_pc_i,
                        prediction: fetch_prediction_i,
                        taken:      fetch_taken_i,
                        pred_pc:    fetch_pred_pc_i};

    // An empty-queue pop resolves against an all-zero entry
    assign head = q_empty ? '0 : rd_entry;

    assign pop_req        = (state_q == BRU_IDLE) && ex_valid_i;
    assign predicted_next = (head.prediction && head.taken) ? head.pred_pc : seq_pc(head.pc);
    assign actual_next    = (ex_branch_i && ex_jumps_i) ? ex_target_pc_i : seq_pc(head.pc);
    assign mispredict     = pop_req && (predicted_next != actual_next);
    assign push_req       = fetch_valid_i && (state_q == BRU_IDLE) && !mispredict
                            && (!q_full || pop_req);

    bru_pred_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i    (clk_i),
        .rsn_i    (rsn_i),
        .push     (push_req),
        .pop      (pop_req),
        .clear    (mispredict),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .full     (q_full),
        .empty    (q_empty)
    );

    // FSM state and flush countdown register
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q     <= BRU_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state: enter FLUSH on a mispredict, leave once the countdown reaches zero
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            BRU_IDLE: begin
                if (mispredict) begin
                    state_d     = BRU_FLUSH;
                    flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            BRU_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = BRU_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d     = BRU_IDLE;
                flush_cnt_d = '0;
            end
        endcase
    end

    // ---- stage p1: feedback and redirect registered one cycle after the pop ----
    always_ff @(posedge clk_i) begin
        if (!rsn_i || !pop_req) begin
            fb_branch_p1     <= 1'b0;
            fb_jumps_p1      <= 1'b0;
            fb_prediction_p1 <= 1'b0;
            fb_taken_p1      <= 1'b0;
            fb_pc_ok_p1      <= 1'b0;
            fb_branch_pc_p1  <= '0;
            fb_target_pc_p1  <= '0;
            redirect_vld_p1  <= 1'b0;
            redirect_pc_p1   <= '0;
        end else begin
            fb_branch_p1     <= ex_branch_i;
            fb_jumps_p1      <= ex_jumps_i;
            fb_prediction_p1 <= head.prediction;
            fb_taken_p1      <= head.taken;
            fb_pc_ok_p1      <= (head.pred_pc == ex_target_pc_i);
            fb_branch_pc_p1  <= head.pc;
            fb_target_pc_p1  <= ex_target_pc_i;
            redirect_vld_p1  <= mispredict;
            redirect_pc_p1   <= mispredict ? actual_next : '0;
        end
    end

`ifdef BRU_STATS_EN
    // Wrapping event counters for resolved branches and mispredicts
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            stat_branch_o     <= '0;
            stat_mispredict_o <= '0;
        end else begin
            if (pop_req && ex_branch_i) begin
                stat_branch_o <= stat_branch_o + 32'd1;
            end
            if (mispredict) begin
                stat_mispredict_o <= stat_mispredict_o + 32'd1;
            end
        end
    end
`endif

    assign fetch_stall_o    = q_full;
    assign flush_o          = (state_q == BRU_FLUSH);
    assign bp_branch_o      = fb_branch_p1;
    assign bp_jumps_o       = fb_jumps_p1;
    assign bp_prediction_o  = fb_prediction_p1;
    assign bp_taken_o       = fb_taken_p1;
    assign bp_pc_ok_o       = fb_pc_ok_p1;
    assign bp_branch_pc_o   = fb_branch_pc_p1;
    assign bp_target_pc_o   = fb_target_pc_p1;
    assign redirect_valid_o = redirect_vld_p1;
    assign redirect_pc_o    = redirect_pc_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a reference model queues the expected
// outputs for each clock edge, which are popped and compared one edge later.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int FLUSH = 2;

    logic        clk = 1'b0;
    logic        rsn;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_prediction;
    logic        fetch_taken;
    logic [31:0] fetch_pred_pc;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_jumps;
    logic [31:0] ex_target_pc;
    logic        fetch_stall;
    logic        bp_branch, bp_jumps, bp_prediction, bp_taken, bp_pc_ok;
    logic [31:0] bp_branch_pc, bp_target_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branch, stat_mispredict;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        br, jm, pr, tk, ok;
        logic [31:0] bpc, tpc;
        logic        rv;
        logic [31:0] rpc;
        logic        fl, st;
        logic [31:0] sbr, smp;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        p, t;
        logic [31:0] ppc;
    } ent_t;

    exp_t        sb[$];
    ent_t        mq[$];
    int          mstate = 0;
    int          mcnt   = 0;
    logic [31:0] m_br   = '0;
    logic [31:0] m_mp   = '0;

    branch_resolve_unit #(
        .QUEUE_DEPTH  (DEPTH),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk_i              (clk),
        .rsn_i              (rsn),
        .fetch_valid_i      (fetch_valid),
        .fetch_pc_i         (fetch_pc),
        .fetch_prediction_i (fetch_prediction),
        .fetch_taken_i      (fetch_taken),
        .fetch_pred_pc_i    (fetch_pred_pc),
        .ex_valid_i         (ex_valid),
        .ex_branch_i        (ex_branch),
        .ex_jumps_i         (ex_jumps),
        .ex_target_pc_i     (ex_target_pc),
        .fetch_stall_o      (fetch_stall),
        .bp_branch_o        (bp_branch),
        .bp_jumps_o         (bp_jumps),
        .bp_prediction_o    (bp_prediction),
        .bp_taken_o         (bp_taken),
        .bp_pc_ok_o         (bp_pc_ok),
        .bp_branch_pc_o     (bp_branch_pc),
        .bp_target_pc_o     (bp_target_pc),
        .redirect_valid_o   (redirect_valid),
        .redirect_pc_o      (redirect_pc),
`ifdef BRU_STATS_EN
        .stat_branch_o      (stat_branch),
        .stat_mispredict_o  (stat_mispredict),
`endif
        .flush_o            (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: expected outputs after the coming edge, given the current inputs
    task automatic model_edge();
        exp_t        e;
        ent_t        h;
        logic [31:0] pn, an;
        bit          mp, full, push;
        e  = '{default: '0};
        mp = 0;
        if (!rsn) begin
            mq.delete();
            mstate = 0;
            mcnt   = 0;
            m_br   = '0;
            m_mp   = '0;
        end else if (mstate == 1) begin
            if (mcnt == 0) begin
                mstate = 0;
            end else begin
                mcnt--;
                e.fl = 1'b1;
            end
        end else begin
            full = (mq.size() == DEPTH);
            h    = '{default: '0};
            if (mq.size() > 0) h = mq[0];
            if (ex_valid) begin
                pn    = (h.p && h.t) ? h.ppc : h.pc + 32'd4;
                an    = (ex_branch && ex_jumps) ? ex_target_pc : h.pc + 32'd4;
                mp    = (pn != an);
                e.br  = ex_branch;
                e.jm  = ex_jumps;
                e.pr  = h.p;
                e.tk  = h.t;
                e.ok  = (h.ppc == ex_target_pc);
                e.bpc = h.pc;
                e.tpc = ex_target_pc;
                if (ex_branch) m_br = m_br + 32'd1;
                if (mp) begin
                    m_mp   = m_mp + 32'd1;
                    e.rv   = 1'b1;
                    e.rpc  = an;
                    e.fl   = 1'b1;
                    mstate = 1;
                    mcnt   = FLUSH - 1;
                end
            end
            push = fetch_valid && !mp && (!full || ex_valid);
            if (mp) begin
                mq.delete();
            end else begin
                if (ex_valid && mq.size() > 0) mq.delete(0);
                if (push) mq.push_back('{fetch_pc, fetch_prediction, fetch_taken, fetch_pred_pc});
            end
        end
        e.st  = (mq.size() == DEPTH);
        e.sbr = m_br;
        e.smp = m_mp;
        sb.push_back(e);
    endtask

    // One clock: record expectation, advance, compare every output against the scoreboard
    task automatic cycle();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("bp_branch", bp_branch, e.br);
        chk("bp_jumps", bp_jumps, e.jm);
        chk("bp_prediction", bp_prediction, e.pr);
        chk("bp_taken", bp_taken, e.tk);
        chk("bp_pc_ok", bp_pc_ok, e.ok);
        chk("bp_branch_pc", bp_branch_pc, e.bpc);
        chk("bp_target_pc", bp_target_pc, e.tpc);
        chk("redirect_valid", redirect_valid, e.rv);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("flush", flush, e.fl);
        chk("fetch_stall", fetch_stall, e.st);
`ifdef BRU_STATS_EN
        chk("stat_branch", stat_branch, e.sbr);
        chk("stat_mispredict", stat_mispredict, e.smp);
`endif
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc, input logic p,
                             input logic t, input logic [31:0] ppc);
        fetch_valid      = v;
        fetch_pc         = pc;
        fetch_prediction = p;
        fetch_taken      = t;
        fetch_pred_pc    = ppc;
    endtask

    task automatic set_ex(input logic v, input logic br, input logic jm, input logic [31:0] tgt);
        ex_valid     = v;
        ex_branch    = br;
        ex_jumps     = jm;
        ex_target_pc = tgt;
    endtask

    task automatic push_only(input logic [31:0] pc, input logic p, input logic t,
                             input logic [31:0] ppc);
        set_fetch(1'b1, pc, p, t, ppc);
        set_ex(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        set_fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pop_only(input logic br, input logic jm, input logic [31:0] tgt);
        set_fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_ex(1'b1, br, jm, tgt);
        cycle();
        set_ex(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic idle_cycle();
        set_fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_ex(1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
    endtask

    initial begin
        rsn = 1'b0;
        set_fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_ex(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        cycle();
        cycle();
        chk("rst_flush", flush, 1'b0);
        chk("rst_stall", fetch_stall, 1'b0);
        rsn = 1'b1;
        idle_cycle();

        // Correctly predicted taken branch
        push_only(32'h100, 1'b1, 1'b1, 32'h200);
        pop_only(1'b1, 1'b1, 32'h200);
        chk("t1_pc_ok", bp_pc_ok, 1'b1);
        chk("t1_no_redirect", redirect_valid, 1'b0);
        idle_cycle();

        // Not predicted but taken: redirect to target, two flush cycles, pushes ignored
        push_only(32'h104, 1'b0, 1'b0, 32'h0);
        pop_only(1'b1, 1'b1, 32'h300);
        chk("t2_redir_vld", redirect_valid, 1'b1);
        chk("t2_redir_pc", redirect_pc, 32'h300);
        chk("t2_flush_c1", flush, 1'b1);
        push_only(32'hABC, 1'b0, 1'b0, 32'h0);
        chk("t2_flush_c2", flush, 1'b1);
        chk("t2_redir_pulse", redirect_valid, 1'b0);
        idle_cycle();
        chk("t2_flush_end", flush, 1'b0);
        pop_only(1'b0, 1'b0, 32'h0);
        chk("t2_queue_empty_pc", bp_branch_pc, 32'h0);

        // Predicted taken but falls through: redirect to pc+4
        push_only(32'h108, 1'b1, 1'b1, 32'h400);
        pop_only(1'b1, 1'b0, 32'h0);
        chk("t3_redir_pc", redirect_pc, 32'h10C);
        idle_cycle();
        idle_cycle();

        // Fill, overflow drop, simultaneous push+pop at full, then drain in order
        for (int i = 0; i < 4; i++) push_only(32'h200 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
        chk("t4_stall_full", fetch_stall, 1'b1);
        push_only(32'h210, 1'b0, 1'b0, 32'h0);
        set_fetch(1'b1, 32'h214, 1'b0, 1'b0, 32'h0);
        set_ex(1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        set_fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t4_pushpop_pc", bp_branch_pc, 32'h200);
        chk("t4_stall_kept", fetch_stall, 1'b1);
        pop_only(1'b0, 1'b0, 32'h0);
        pop_only(1'b0, 1'b0, 32'h0);
        pop_only(1'b0, 1'b0, 32'h0);
        pop_only(1'b0, 1'b0, 32'h0);
        chk("t4_last_pc", bp_branch_pc, 32'h214);

        // Reset during flush
        push_only(32'h300, 1'b0, 1'b0, 32'h0);
        pop_only(1'b1, 1'b1, 32'h500);
        chk("t5_in_flush", flush, 1'b1);
        rsn = 1'b0;
        idle_cycle();
        chk("t5_flush_cleared", flush, 1'b0);
        chk("t5_stall_cleared", fetch_stall, 1'b0);
        rsn = 1'b1;
        idle_cycle();

        // Three branches, one mispredict
        push_only(32'h400, 1'b1, 1'b1, 32'h500);
        push_only(32'h404, 1'b0, 1'b0, 32'h0);
        push_only(32'h408, 1'b0, 1'b0, 32'h0);
        pop_only(1'b1, 1'b1, 32'h500);
        pop_only(1'b1, 1'b0, 32'h600);
        pop_only(1'b1, 1'b1, 32'h700);
        chk("t6_redir_pc", redirect_pc, 32'h700);
`ifdef BRU_STATS_EN
        chk("t6_stat_branch", stat_branch, 32'd3);
        chk("t6_stat_mispredict", stat_mispredict, 32'd1);
`endif
        idle_cycle();
        idle_cycle();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            set_fetch(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * $urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      32'h1000 + 32'(4 * $urandom_range(0, 7)));
            set_ex(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * $urandom_range(0, 7)));
            cycle();
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side counterpart of the fetch-stage branch predictor. Carries each fetched instruction's prediction metadata in program order until the instruction leaves the ALU, then compares the predicted next PC against the resolved outcome. Drives the predictor's training/feedback inputs, and on a misprediction drives a redirect PC and a multi-cycle pipeline flush. Sits between the ALU output and the fetch/predictor logic.

## Interface
- QUEUE_DEPTH, 4: in-flight prediction entries (power of two, ≥2)
- FLUSH_CYCLES, 2: cycles flush_o stays high per mispredict (≥1)
- clk_i  in  1  clock, all logic on rising edge
- rsn_i  in  1  reset, synchronous, active-low
- fetch_valid_i  in  1  fetched instruction pushes its prediction entry
- fetch_pc_i  in  32  PC of fetched instruction
- fetch_prediction_i  in  1  predictor BTB hit for fetch_pc_i
- fetch_taken_i  in  1  predictor taken bit
- fetch_pred_pc_i  in  32  predictor target PC
- ex_valid_i  in  1  instruction leaving ALU; pops queue head
- ex_branch_i  in  1  instruction is a branch/jump
- ex_jumps_i  in  1  branch actually taken
- ex_target_pc_i  in  32  resolved target PC
- fetch_stall_o  out  1  queue full (combinational)
- bp_branch_o, bp_jumps_o, bp_prediction_o, bp_taken_o, bp_pc_ok_o  out  1 each  predictor feedback fields
- bp_branch_pc_o, bp_target_pc_o  out  32 each  resolved branch PC / target
- redirect_valid_o  out  1  one-cycle redirect pulse
- redirect_pc_o  out  32  correct next PC
- flush_o  out  1  squash younger pipeline state

## Operation
- Queue entry {pc, prediction, taken, pred_pc}; FIFO, program order.
- Push when fetch_valid_i && !full && state==IDLE && no mispredict this cycle; push when full without simultaneous pop is dropped.
- Pop on ex_valid_i in IDLE; empty-queue pop uses entry {ex pc=0, prediction=0, taken=0, pred_pc=0}.
- predicted_next = (prediction & taken) ? pred_pc : pc+4 (32-bit wrap).
- actual_next = (ex_branch_i & ex_jumps_i) ? ex_target_pc_i : pc+4.
- mispredict = ex_valid_i & (predicted_next != actual_next).
- Feedback registered on every pop: bp_branch_o=ex_branch_i, bp_jumps_o=ex_jumps_i, bp_prediction_o=prediction, bp_taken_o=taken, bp_pc_ok_o=(pred_pc==ex_target_pc_i), bp_branch_pc_o=pc, bp_target_pc_o=ex_target_pc_i; fields zero in cycles without pop.
- FSM: IDLE -> FLUSH on mispredict (redirect_valid_o=1, redirect_pc_o=actual_next, flush_o=1, queue cleared, counter=FLUSH_CYCLES-1); FLUSH counts down, ex_valid_i/fetch_valid_i ignored, flush_o=1; counter==0 -> IDLE.
- Simultaneous push+pop when full: both occur, count unchanged.

## Timing
- Reset: all outputs 0, queue empty, state IDLE; reset mid-FLUSH returns to IDLE next edge.
- Feedback and redirect: 1 cycle after the ex_valid_i edge.
- flush_o high exactly FLUSH_CYCLES consecutive cycles, first cycle coincides with redirect_valid_o.
- fetch_stall_o reflects count==QUEUE_DEPTH this cycle; pointers wrap modulo QUEUE_DEPTH.

## Configuration
- BRU_STATS_EN defined: adds outputs stat_branch_o and stat_mispredict_o (32 each, wrapping), incremented on popped ex_branch_i and on mispredict; cleared on reset.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package bru_pkg: state enum (BRU_IDLE, BRU_FLUSH), queue-entry struct, PC_STEP=4.
- Sub-module bru_pred_queue: parameterised FIFO with push/pop/clear/full/empty; top holds compare, feedback regs, FSM.

## Test plan
- Push {pc=0x100,pred=1,taken=1,pred_pc=0x200}; ex pops with branch=1,jumps=1,target=0x200 -> no redirect, bp_pc_ok_o=1 next cycle.
- Push {0x104,pred=0}; ex branch=1,jumps=1,target=0x300 -> redirect_valid_o=1, redirect_pc_o=0x300, flush_o high 2 cycles, queue empty.
- Push {0x108,pred=1,taken=1,pred_pc=0x400}; ex branch=1,jumps=0 -> redirect_pc_o=0x10C.
- Push 4 entries -> fetch_stall_o=1; 5th push dropped; push+pop same cycle keeps count 4.
- Drop rsn_i during FLUSH -> next cycle flush_o=0, state IDLE, fetch_stall_o=0.
- BRU_STATS_EN: 3 branches, 1 mispredict -> stat_branch_o=3, stat_mispredict_o=1.
